// File: rtl/lsu_mem_if_rv32i.sv
// RV32I data-memory interface: one request at a time, legality checks,
// word bus with byte strobes, ack timeout, right-justified load data.
module lsu_mem_if_rv32i #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] dmem_out,
   output logic        resp_valid,
   output logic [1:0]  fault,
   output logic        stall
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0] F_OK    = 2'b00;
   localparam logic [1:0] F_MISAL = 2'b01;
   localparam logic [1:0] F_TMO   = 2'b10;
   localparam logic [1:0] F_ILL   = 2'b11;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [1:0]  w_fault_nxt;
   logic        w_bus_go;
   logic        w_ack_hit;

   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_wstrb;
   logic [31:0] r_mem_wdata;
   logic [1:0]  r_lane;
   logic [31:0] r_dmem_out;
   logic        r_resp_valid;
   logic [1:0]  r_fault;

   logic        w_illegal;
   logic        w_is_half;
   logic        w_is_word;
   logic        w_misal;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;

   // Request legality: type range first, then natural alignment
   always_comb begin
      w_illegal = req_we ? (req_type > 3'b010) : (req_type > 3'b100);
      w_is_half = (req_type == 3'b001) ||
                  (!req_we && (req_type == 3'b100));
      w_is_word = (req_type == 3'b010);
      w_misal   = (w_is_half && req_addr[0]) ||
                  (w_is_word && (req_addr[1:0] != 2'b00));
   end

   // Store lane strobes and replicated data; loads never strobe
   always_comb begin
      w_wstrb = 4'b1111;
      w_wdata = req_wdata;
      case (req_type[1:0])
         2'b00: begin
            w_wstrb = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_wstrb = 4'b0011 << {req_addr[1], 1'b0};
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_wstrb = 4'b1111;
            w_wdata = req_wdata;
         end
      endcase
      if (!req_we) begin
         w_wstrb = 4'b0000;
      end
   end

   // Next state, timeout count and fault code
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fault_nxt = F_OK;
      w_bus_go    = 1'b0;
      w_ack_hit   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_illegal) begin
                  w_state_nxt = S_RESP;
                  w_fault_nxt = F_ILL;
               end else if (w_misal) begin
                  w_state_nxt = S_RESP;
                  w_fault_nxt = F_MISAL;
               end else begin
                  w_state_nxt = S_BUS;
                  w_cnt_nxt   = 8'd0;
                  w_bus_go    = 1'b1;
               end
            end
         end
         S_BUS: begin
            if (mem_ack) begin
               w_state_nxt = S_RESP;
               w_ack_hit   = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_RESP;
               w_fault_nxt = F_TMO;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and timeout counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Bus fields captured at accept and held stable through BUS
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wstrb <= 4'd0;
         r_mem_wdata <= 32'd0;
         r_lane      <= 2'd0;
      end else begin
         r_mem_req <= (w_state_nxt == S_BUS);
         if (w_bus_go) begin
            r_mem_we    <= req_we;
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_wstrb <= w_wstrb;
            r_mem_wdata <= w_wdata;
            r_lane      <= req_addr[1:0];
         end
      end
   end

   // Response pulse, fault code and load data return
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_fault      <= 2'b00;
         r_dmem_out   <= 32'd0;
      end else begin
         r_resp_valid <= (w_state_nxt == S_RESP);
         r_fault      <= w_fault_nxt;
         if (w_ack_hit && !r_mem_we) begin
            r_dmem_out <= mem_rdata >> {r_lane, 3'b000};
         end
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign stall      = (r_state != S_IDLE);
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wstrb  = r_mem_wstrb;
   assign mem_wdata  = r_mem_wdata;
   assign dmem_out   = r_dmem_out;
   assign resp_valid = r_resp_valid;
   assign fault      = r_fault;

endmodule

// File: tb/tb_lsu_mem_if_rv32i.sv
// Directed bench for lsu_mem_if_rv32i with a 4-cycle bus timeout.
module tb_lsu_mem_if_rv32i;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] dmem_out;
   logic        resp_valid;
   logic [1:0]  fault;
   logic        stall;

   int n_cmp = 0;
   int n_err = 0;

   lsu_mem_if_rv32i #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_type   (req_type),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .dmem_out   (dmem_out),
      .resp_valid (resp_valid),
      .fault      (fault),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_at;
      logic [31:0] rdata;
      logic [1:0]  efault;
      logic        ebus;
      logic [31:0] eaddr;
      logic [3:0]  estrb;
      logic [31:0] ewdata;
      logic [31:0] edout;
      int          elat;
      int          ereq;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int k;
      int reqcnt;
      string t;
      v = tbl[idx];
      t = $sformatf("v%0d", idx);
      @(negedge clk);
      chk({t, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_type  = v.typ;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk({t, ".mem_req"}, 32'(mem_req), 32'(v.ebus));
      if (v.ebus) begin
         chk({t, ".addr"}, mem_addr, v.eaddr);
         chk({t, ".wstrb"}, 32'(mem_wstrb), 32'(v.estrb));
         chk({t, ".we"}, 32'(mem_we), 32'(v.we));
         if (v.we) chk({t, ".wdata"}, mem_wdata, v.ewdata);
      end
      k = 0;
      reqcnt = 0;
      while (!resp_valid && k < 40) begin
         if (mem_req) reqcnt++;
         mem_ack   = mem_req && (k + 1 == v.ack_at);
         mem_rdata = v.rdata;
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         k++;
      end
      chk({t, ".resp"}, 32'(resp_valid), 32'd1);
      chk({t, ".lat"}, 32'(k + 1), 32'(v.elat));
      chk({t, ".reqcyc"}, 32'(reqcnt), 32'(v.ereq));
      chk({t, ".fault"}, 32'(fault), 32'(v.efault));
      chk({t, ".dout"}, dmem_out, v.edout);
      chk({t, ".req_off"}, 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      chk({t, ".pulse"}, 32'(resp_valid), 32'd0);
      chk({t, ".f_idle"}, 32'(fault), 32'd0);
   endtask

   initial begin
      //         we typ     addr       wdata      ack rdata
      //         flt   bus  eaddr      strb    ewdata      edout    lat req
      tbl[0]  = '{0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF,
                 2'b00, 1, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 2, 1};
      tbl[1]  = '{0, 3'b000, 32'h203, 32'h0, 1, 32'h80112233,
                 2'b00, 1, 32'h200, 4'b0000, 32'h0, 32'h00000080, 2, 1};
      tbl[2]  = '{0, 3'b100, 32'h202, 32'h0, 1, 32'h80112233,
                 2'b00, 1, 32'h200, 4'b0000, 32'h0, 32'h00008011, 2, 1};
      tbl[3]  = '{1, 3'b000, 32'h301, 32'hA5, 1, 32'hFFFFFFFF,
                 2'b00, 1, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h00008011, 2, 1};
      tbl[4]  = '{1, 3'b001, 32'h302, 32'h1234, 1, 32'hFFFFFFFF,
                 2'b00, 1, 32'h300, 4'b1100, 32'h12341234, 32'h00008011, 2, 1};
      tbl[5]  = '{0, 3'b010, 32'h101, 32'h0, 0, 32'h0,
                 2'b01, 0, 32'h0, 4'b0000, 32'h0, 32'h00008011, 1, 0};
      tbl[6]  = '{1, 3'b011, 32'h100, 32'h0, 0, 32'h0,
                 2'b11, 0, 32'h0, 4'b0000, 32'h0, 32'h00008011, 1, 0};
      tbl[7]  = '{0, 3'b111, 32'h101, 32'h0, 0, 32'h0,
                 2'b11, 0, 32'h0, 4'b0000, 32'h0, 32'h00008011, 1, 0};
      tbl[8]  = '{0, 3'b001, 32'h201, 32'h0, 0, 32'h0,
                 2'b01, 0, 32'h0, 4'b0000, 32'h0, 32'h00008011, 1, 0};
      tbl[9]  = '{0, 3'b010, 32'h104, 32'h0, 0, 32'h12345678,
                 2'b10, 1, 32'h104, 4'b0000, 32'h0, 32'h00008011, 5, 4};
      tbl[10] = '{0, 3'b010, 32'h108, 32'h0, 4, 32'hCAFEF00D,
                 2'b00, 1, 32'h108, 4'b0000, 32'h0, 32'hCAFEF00D, 5, 4};
      tbl[11] = '{1, 3'b010, 32'h304, 32'h11223344, 2, 32'h0,
                 2'b00, 1, 32'h304, 4'b1111, 32'h11223344, 32'hCAFEF00D, 3, 2};
      tbl[12] = '{0, 3'b001, 32'h202, 32'h0, 1, 32'h80112233,
                 2'b00, 1, 32'h200, 4'b0000, 32'h0, 32'h00008011, 2, 1};
      tbl[13] = '{0, 3'b000, 32'h201, 32'h0, 3, 32'h80112233,
                 2'b00, 1, 32'h200, 4'b0000, 32'h0, 32'h00801122, 4, 3};
      tbl[14] = '{0, 3'b010, 32'h110, 32'h0, 1, 32'h0BADF00D,
                 2'b00, 1, 32'h110, 4'b0000, 32'h0, 32'h0BADF00D, 2, 1};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_type  = 3'b000;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.mem_req", 32'(mem_req), 32'd0);
      chk("rst.stall", 32'(stall), 32'd0);
      chk("rst.resp", 32'(resp_valid), 32'd0);
      chk("rst.fault", 32'(fault), 32'd0);
      chk("rst.dout", dmem_out, 32'd0);
      chk("rst.wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst.addr", mem_addr, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run_vec(i);
      end

      // ack while idle must not disturb anything
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      chk("idle_ack.dout", dmem_out, 32'h00801122);
      chk("idle_ack.resp", 32'(resp_valid), 32'd0);
      chk("idle_ack.stall", 32'(stall), 32'd0);

      // reset in the middle of a bus access
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_type  = 3'b010;
      req_addr  = 32'h10C;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("mid.busy", 32'(mem_req), 32'd1);
      chk("mid.ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("mid.stall", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid.req_drop", 32'(mem_req), 32'd0);
      chk("mid.stall_drop", 32'(stall), 32'd0);
      chk("mid.resp", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("mid.resp2", 32'(resp_valid), 32'd0);
      chk("mid.dout", dmem_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid.resp3", 32'(resp_valid), 32'd0);
      run_vec(14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
